// File: rtl/module_data_bus_responder_pkg.sv
// Address map, CTRL bit positions and region decode for the data-bus responder.
package pkg_data_bus_map;

  localparam logic [31:0] RAM_BASE      = 32'h0000_1000;
  localparam logic [31:0] LED_ADDR      = 32'h0000_2000;
  localparam logic [31:0] SW_ADDR       = 32'h0000_2004;
  localparam logic [31:0] CTRL_ADDR     = 32'h0000_2008;
  localparam logic [31:0] PRESCALE_ADDR = 32'h0000_200C;
  localparam logic [31:0] COUNT_ADDR    = 32'h0000_2010;
  localparam logic [31:0] CMP_ADDR      = 32'h0000_2014;
  localparam logic [31:0] STATUS_ADDR   = 32'h0000_2018;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_AR  = 1;
  localparam int CTRL_IRQ = 2;

  typedef enum logic [3:0] {
    REG_RAM, REG_LED, REG_SW, REG_CTRL, REG_PRESCALE,
    REG_COUNT, REG_CMP, REG_STATUS, REG_NONE
  } region_e;

  // Byte-lane bits are dropped before matching, so any address inside a word hits it.
  function automatic region_e decode(input logic [31:0] addr, input int ram_words);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    if (a >= RAM_BASE && a < RAM_BASE + 32'(4 * ram_words)) return REG_RAM;
    case (a)
      LED_ADDR:      return REG_LED;
      SW_ADDR:       return REG_SW;
      CTRL_ADDR:     return REG_CTRL;
      PRESCALE_ADDR: return REG_PRESCALE;
      COUNT_ADDR:    return REG_COUNT;
      CMP_ADDR:      return REG_CMP;
      STATUS_ADDR:   return REG_STATUS;
      default:       return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/module_data_bus_responder_timer32.sv
// Prescaled 32-bit timer with compare match, sticky MATCH flag and level interrupt.
module module_timer32
  import pkg_data_bus_map::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wdata_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_presc_i,
  input  logic        wr_count_i,
  input  logic        wr_cmp_i,
  input  logic        wr_status_i,
  output logic [2:0]  ctrl_o,
  output logic [15:0] presc_o,
  output logic [31:0] count_o,
  output logic [31:0] cmp_o,
  output logic        match_o,
  output logic        irq_o
);

  logic [2:0]  ctrl_q,  ctrl_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] pcnt_q,  pcnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q,   cmp_d;
  logic        match_q, match_d;
  logic        tick, hit;

  assign tick = ctrl_q[CTRL_EN] && (pcnt_q == presc_q);
  assign hit  = tick && (count_q == cmp_q);

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;

    if (ctrl_q[CTRL_EN]) pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
    if (hit && ctrl_q[CTRL_AR]) count_d = '0;
    else if (tick)              count_d = count_q + 32'd1;

    if (wr_ctrl_i)  ctrl_d  = wdata_i[2:0];
    if (wr_presc_i) presc_d = wdata_i[15:0];
    if (wr_cmp_i)   cmp_d   = wdata_i;
    if (wr_count_i) count_d = wdata_i;
    if (wr_ctrl_i || wr_presc_i || wr_count_i) pcnt_d = '0;

    // Clear is applied first so a coincident match set takes priority.
    if (wr_status_i && wdata_i[0]) match_d = 1'b0;
    if (hit) match_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign presc_o = presc_q;
  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign match_o = match_q;
  assign irq_o   = match_q & ctrl_q[CTRL_IRQ];

endmodule

// File: rtl/module_data_bus_responder.sv
// Data-bus responder: word RAM, LED register, synchronized switches and timer,
// with combinational read data for the single-cycle load path.
module module_data_bus_responder
  import pkg_data_bus_map::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int IO_W      = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  input  logic [IO_W-1:0] sw_i,
  output logic [IO_W-1:0] led_o,
  output logic            irq_o
);

  localparam int AW = $clog2(RAM_WORDS);

  region_e        region;
  logic [AW-1:0]  ram_idx;
  logic [31:0]    ram_q [RAM_WORDS];
  logic [IO_W-1:0] led_q, sw_meta_q, sw_sync_q;

  logic [2:0]  t_ctrl;
  logic [15:0] t_presc;
  logic [31:0] t_count, t_cmp;
  logic        t_match;

  assign region  = decode(addr_i, RAM_WORDS);
  assign ram_idx = addr_i[AW+1:2];

  // RAM contents are intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i && region == REG_RAM) ram_q[ram_idx] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      if (we_i && region == REG_LED) led_q <= wdata_i[IO_W-1:0];
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  module_timer32 u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wdata_i     (wdata_i),
    .wr_ctrl_i   (we_i && region == REG_CTRL),
    .wr_presc_i  (we_i && region == REG_PRESCALE),
    .wr_count_i  (we_i && region == REG_COUNT),
    .wr_cmp_i    (we_i && region == REG_CMP),
    .wr_status_i (we_i && region == REG_STATUS),
    .ctrl_o      (t_ctrl),
    .presc_o     (t_presc),
    .count_o     (t_count),
    .cmp_o       (t_cmp),
    .match_o     (t_match),
    .irq_o       (irq_o)
  );

  always_comb begin
    rdata_o = '0;
    case (region)
      REG_RAM:      rdata_o = ram_q[ram_idx];
      REG_LED:      rdata_o = 32'(led_q);
      REG_SW:       rdata_o = 32'(sw_sync_q);
      REG_CTRL:     rdata_o = 32'(t_ctrl);
      REG_PRESCALE: rdata_o = 32'(t_presc);
      REG_COUNT:    rdata_o = t_count;
      REG_CMP:      rdata_o = t_cmp;
      REG_STATUS:   rdata_o = 32'(t_match);
      default:      rdata_o = '0;
    endcase
  end

  assign led_o = led_q;

endmodule

// File: tb/tb_module_data_bus_responder.sv
// Directed bench for the data-bus responder: map, RAM, LED/SW and timer scenarios.
module tb_module_data_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr, wdata, rdata;
  logic [15:0] sw, led;
  logic        irq;

  int total = 0;
  int bad   = 0;

  module_data_bus_responder #(.RAM_WORDS(256), .IO_W(16)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .sw_i    (sw),
    .led_o   (led),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; one rising edge commits, returns at the next negedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; sw = '0;
    @(negedge clk);
    rd("rst_led",    32'h2000, 32'h0);
    rd("rst_ctrl",   32'h2008, 32'h0);
    rd("rst_count",  32'h2010, 32'h0);
    rd("rst_status", 32'h2018, 32'h0);
    chk("rst_led_o", 32'(led), 32'h0);
    chk("rst_irq",   32'(irq), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // RAM and unmapped space
    wr(32'h1008, 32'h1234_5678);
    wr(32'h1004, 32'hDEAD_BEEF);
    rd("ram_1004",   32'h1004, 32'hDEAD_BEEF);
    rd("ram_bytes",  32'h1007, 32'hDEAD_BEEF);
    rd("ram_1008",   32'h1008, 32'h1234_5678);
    wr(32'h13FC, 32'hCAFE_0001);
    rd("ram_top",    32'h13FC, 32'hCAFE_0001);
    rd("past_ram",   32'h1400, 32'h0);
    wr(32'h3000, 32'h5555_AAAA);
    rd("unmapped",   32'h3000, 32'h0);
    rd("ram_keep",   32'h1004, 32'hDEAD_BEEF);
    rd("led_keep",   32'h2000, 32'h0);

    // LED and switch sync
    wr(32'h2000, 32'h0000_00A5);
    chk("led_o", 32'(led), 32'h00A5);
    rd("led_rd",  32'h2000, 32'h00A5);
    wr(32'h2004, 32'hFFFF_FFFF);
    rd("sw_ro",   32'h2004, 32'h0);
    @(negedge clk);
    sw = 16'h1234;
    @(posedge clk); #1;
    rd("sw_1edge", 32'h2004, 32'h0);
    @(posedge clk); #1;
    rd("sw_2edge", 32'h2004, 32'h1234);
    @(negedge clk);

    // Register widths
    wr(32'h200C, 32'h0001_2345);
    rd("presc_w",  32'h200C, 32'h2345);
    wr(32'h2008, 32'h0000_00F8);
    rd("ctrl_w",   32'h2008, 32'h0);

    // Prescaled count with autoreload and irq
    wr(32'h200C, 32'd3);
    wr(32'h2014, 32'd2);
    wr(32'h2008, 32'b111);
    repeat (3) @(negedge clk);
    rd("t_k3",  32'h2010, 32'd0);
    @(negedge clk);
    rd("t_k4",  32'h2010, 32'd1);
    repeat (4) @(negedge clk);
    rd("t_k8",  32'h2010, 32'd2);
    repeat (3) @(negedge clk);
    rd("t_k11", 32'h2010, 32'd2);
    chk("t_k11_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rd("t_k12_cnt",   32'h2010, 32'd0);
    rd("t_k12_match", 32'h2018, 32'd1);
    chk("t_k12_irq", 32'(irq), 32'h1);
    wr(32'h2018, 32'h1);
    chk("irq_clr", 32'(irq), 32'h0);
    rd("match_clr", 32'h2018, 32'd0);

    // Wrap, then software write beats a tick
    wr(32'h2008, 32'h0);
    wr(32'h2010, 32'hFFFF_FFFF);
    wr(32'h200C, 32'h0);
    wr(32'h2014, 32'd5);
    wr(32'h2008, 32'b001);
    rd("pre_wrap",  32'h2010, 32'hFFFF_FFFF);
    @(negedge clk);
    rd("wrap",      32'h2010, 32'h0);
    rd("wrap_nm",   32'h2018, 32'h0);
    @(negedge clk);
    rd("inc1",      32'h2010, 32'h1);
    wr(32'h2010, 32'h10);
    rd("sw_over",   32'h2010, 32'h10);
    @(negedge clk);
    rd("after_ov",  32'h2010, 32'h11);

    // Set beats clear on the same edge
    wr(32'h2010, 32'd5);
    wr(32'h2018, 32'h1);
    rd("set_wins",  32'h2018, 32'h1);
    rd("set_cnt",   32'h2010, 32'd6);
    chk("irq_dis",  32'(irq), 32'h0);

    // Mid-count reset
    @(negedge clk);
    rst = 1'b1;
    #1;
    rd("mrst_cnt",  32'h2010, 32'h0);
    rd("mrst_ctrl", 32'h2008, 32'h0);
    rd("mrst_stat", 32'h2018, 32'h0);
    rd("mrst_cmp",  32'h2014, 32'h0);
    chk("mrst_led", 32'(led), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rd("mrst_hold", 32'h2010, 32'h0);
    rd("mrst_ram",  32'h1004, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/module_data_bus_responder.md
# module_data_bus_responder

Memory-mapped responder on the single-cycle core's data bus: it receives `we`, address and write data and returns read data combinationally in the same cycle, as the single-cycle load path requires. It contains:
- a word-addressed data RAM;
- a LED output register;
- a synchronized switch input;
- a prescaled 32-bit timer with compare match, sticky flag and interrupt.

It sits beside the program ROM at the top level, wired directly to the core's data-bus outputs and read-data input.

## Interface
- `RAM_WORDS`, 256, data RAM depth in 32-bit words (power of two, ≤1024)
- `IO_W`, 16, width of LED and switch ports
- `clk_i`  in  1  system clock, all state on rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `we_i`  in  1  write strobe from core, valid for the current cycle
- `addr_i`  in  32  byte address from core; bits [1:0] ignored
- `wdata_i`  in  32  store data from core
- `rdata_o`  out  32  load data to core, combinational from `addr_i`
- `sw_i`  in  IO_W  asynchronous board switches
- `led_o`  out  IO_W  LED register value
- `irq_o`  out  1  timer interrupt level

## Operation
Memory map (word-aligned):
- 0x1000–0x1000+4·RAM_WORDS−4: RAM, index = `addr_i`[log2(RAM_WORDS)+1:2]
- 0x2000 LED: RW, low IO_W bits
- 0x2004 SW: RO, 2-flop-synchronized `sw_i`, zero-extended
- 0x2008 CTRL: RW bits[2:0]: bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN; upper bits read 0
- 0x200C PRESCALE: RW, low 16 bits
- 0x2010 COUNT: RW, 32 bits
- 0x2014 CMP: RW, 32 bits
- 0x2018 STATUS: bit0 MATCH (sticky); write 1 to bit0 clears it, write 0 has no effect

Decode and access rules:
- Any other address: reads return 0, writes ignored; no side effects.
- Writes to SW are ignored.

Timer behaviour:
- With EN=1, the prescale counter runs 0..PRESCALE. When it equals PRESCALE it returns to 0 and raises a one-cycle internal tick.
- PRESCALE=0 gives a tick every cycle.
- On a tick, if COUNT==CMP: MATCH←1, and COUNT←0 when AUTORELOAD=1, otherwise COUNT←COUNT+1.
- On a tick with no match: COUNT←COUNT+1, mod 2^32, so 0xFFFF_FFFF wraps to 0.
- EN=0 freezes both the prescale counter and COUNT, holding their values.
- A write to CTRL, PRESCALE or COUNT clears the prescale counter.
- `irq_o` = MATCH & IRQ_EN.

Simultaneous events:
- A software write to COUNT overrides a tick increment or reload in the same cycle.
- A MATCH set and a STATUS clear in the same cycle: set wins.
- A write to CMP takes effect for compares starting the next cycle.

## Timing
- Reads are purely combinational (`addr_i` → `rdata_o`). A read in the same cycle as a write to that location returns the old value.
- Writes commit on the rising edge at the end of the cycle with `we_i`=1.
- Writes are visible to reads from the next cycle.
- SW latency: a `sw_i` change appears at the SW read after 2 rising edges.
- `irq_o` is registered-flag based: it asserts in the cycle after the matching tick edge.

Reset (asynchronous):
- `led_o`=0, SW sync flops=0, CTRL=0, PRESCALE=0, COUNT=0, CMP=0, MATCH=0, prescale counter=0, `irq_o`=0.
- `rdata_o` reflects these values immediately.
- RAM contents are not reset (undefined until written).
- Reset asserted mid-count stops the timer at once; counting restarts only after software sets EN.

## Structure
- Package `pkg_data_bus_map`:
  - address constants (RAM_BASE, LED_ADDR, SW_ADDR, CTRL_ADDR, PRESCALE_ADDR, COUNT_ADDR, CMP_ADDR, STATUS_ADDR);
  - CTRL bit-index constants;
  - an enum for the decoded region (REG_RAM, REG_LED, REG_SW, REG_CTRL, REG_PRESCALE, REG_COUNT, REG_CMP, REG_STATUS, REG_NONE).
- Sub-module `module_timer32` holds:
  - prescale counter;
  - COUNT, CMP, CTRL and MATCH;
  - write ports from the decoder.

  It outputs register values and `irq_o`.
- The RAM is inferred in the top module as a distributed array: combinational read, synchronous write.

## Test plan
- Reset, then read 0x2000, 0x2008, 0x2010, 0x2018 → all 0; `led_o`=0, `irq_o`=0.
- Write 0xDEADBEEF to 0x1004, then read 0x1004 → 0xDEADBEEF. Read 0x1008 → unchanged. Read 0x3000 → 0, and a write to 0x3000 alters nothing.
- Write 0x00A5 to 0x2000 → `led_o`=0x00A5 next cycle. Drive `sw_i`=0x1234 → reading 0x2004 returns 0x1234 after exactly 2 edges.
- Write PRESCALE=3, CMP=2, CTRL=0b111 → COUNT advances every 4 cycles: 0,1,2. At the tick with COUNT==2, COUNT returns to 0, MATCH=1 and `irq_o`=1 the next cycle. Write 1 to 0x2018 → `irq_o`=0.
- Write COUNT=0xFFFF_FFFF, PRESCALE=0, CMP=5, CTRL=0b001 → next tick gives COUNT=0 (wrap) and MATCH stays 0. Then, in a cycle where a tick would increment COUNT, write COUNT=0x10 → COUNT reads 0x10, not an incremented value.
- Clear MATCH by writing 1 to 0x2018 in the same cycle as a matching tick → MATCH remains 1. Assert `rst_i` mid-count → all registers 0 immediately and COUNT holds 0 with `rst_i` released and EN=0.
